multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 172 +++++++++++++++++
 tb/tb_multicycle_control.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
//------------------------------------------------------------------------------
// Module      : multicycle_control
// Description : Main control FSM for a multicycle MIPS-style datapath.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  localparam logic [3:0] c_FETCH     = 4'd0;
  localparam logic [3:0] c_DECODE    = 4'd1;
  localparam logic [3:0] c_MEM_ADDR  = 4'd2;
  localparam logic [3:0] c_MEM_READ  = 4'd3;
  localparam logic [3:0] c_MEM_WB    = 4'd4;
  localparam logic [3:0] c_MEM_WRITE = 4'd5;
  localparam logic [3:0] c_EXECUTE   = 4'd6;
  localparam logic [3:0] c_R_WB      = 4'd7;
  localparam logic [3:0] c_BRANCH    = 4'd8;
  localparam logic [3:0] c_JUMP      = 4'd9;
  localparam logic [3:0] c_ADDI_EX   = 4'd10;
  localparam logic [3:0] c_ADDI_WB   = 4'd11;

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic       w_op_supported;

  assign w_op_supported = (opcode == c_OP_RTYPE) || (opcode == c_OP_LW) ||
                          (opcode == c_OP_SW)    || (opcode == c_OP_BEQ) ||
                          (opcode == c_OP_J)     || (opcode == c_OP_ADDI);

  assign state = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = c_FETCH;
    case (r_state)
      c_FETCH:     w_next_state = mem_ready ? c_DECODE : c_FETCH;
      c_DECODE: begin
        case (opcode)
          c_OP_LW, c_OP_SW: w_next_state = c_MEM_ADDR;
          c_OP_RTYPE:       w_next_state = c_EXECUTE;
          c_OP_BEQ:         w_next_state = c_BRANCH;
          c_OP_J:           w_next_state = c_JUMP;
          c_OP_ADDI:        w_next_state = c_ADDI_EX;
          default:          w_next_state = c_FETCH;
        endcase
      end
      // opcode is held from DECODE, so only lw/sw ever reach MEM_ADDR
      c_MEM_ADDR:  w_next_state = (opcode == c_OP_SW) ? c_MEM_WRITE : c_MEM_READ;
      c_MEM_READ:  w_next_state = mem_ready ? c_MEM_WB : c_MEM_READ;
      c_MEM_WRITE: w_next_state = mem_ready ? c_FETCH : c_MEM_WRITE;
      c_EXECUTE:   w_next_state = c_R_WB;
      c_ADDI_EX:   w_next_state = c_ADDI_WB;
      default:     w_next_state = c_FETCH;
    endcase
  end

  // Outputs are forced low while rst is high, independent of the clock.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    if (!rst) begin
      case (r_state)
        c_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        c_DECODE: begin
          alu_src_b  = 2'b11;
          illegal_op = ~w_op_supported;
        end
        c_MEM_ADDR, c_ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        c_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        c_MEM_WRITE: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
        end
        c_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        c_EXECUTE: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        c_R_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        c_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          instr_done    = 1'b1;
        end
        c_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = 2'b10;
          instr_done = 1'b1;
        end
        c_ADDI_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
//------------------------------------------------------------------------------
// Module      : tb_multicycle_control
// Description : Directed-vector bench for the multicycle control FSM.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic       instr_done, illegal_op;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
  //  pc_source, instr_done, illegal_op}
  logic [17:0] ctrl;
  assign ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                 pc_source, instr_done, illegal_op};

  localparam logic [17:0] C_ZERO       = 18'b0;
  localparam logic [17:0] C_FETCH_RDY  = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] C_FETCH_WAIT = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] C_DECODE     = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] C_DECODE_ILL = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_1;
  localparam logic [17:0] C_ADDR       = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] C_MEM_READ   = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] C_MEM_WB     = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
  localparam logic [17:0] C_MW_RDY     = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] C_MW_WAIT    = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] C_EXECUTE    = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] C_R_WB       = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [17:0] C_BRANCH     = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [17:0] C_JUMP       = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
  localparam logic [17:0] C_ADDI_WB    = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;

  // Write strobes must never overlap a conflicting strobe.
  always begin
    @(negedge clk);
    #2;
    if (checking) begin
      total++;
      if ((mem_read && mem_write) || (reg_write && mem_write)) begin
        bad++;
        $display("FAIL strobe_overlap: mem_read=%b mem_write=%b reg_write=%b required no overlap",
                 mem_read, mem_write, reg_write);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (state !== 4'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
    total++;
    if (ctrl !== C_ZERO) begin bad++; $display("FAIL reset_ctrl: got %b want %b", ctrl, C_ZERO); end
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
    checking = 1'b1;
    #1;
    total++;
    if (state !== 4'd0) begin bad++; $display("FAIL release_state: got %0d want 0", state); end
    total++;
    if (ctrl !== C_FETCH_WAIT) begin bad++; $display("FAIL release_ctrl: got %b want %b", ctrl, C_FETCH_WAIT); end
  endtask

  task automatic test_lw();
    logic [22:0] seq [6];
    seq = '{ {1'b0, 4'd0, C_FETCH_WAIT}, {1'b1, 4'd0, C_FETCH_RDY},
             {1'b1, 4'd1, C_DECODE},     {1'b1, 4'd2, C_ADDR},
             {1'b1, 4'd3, C_MEM_READ},   {1'b1, 4'd4, C_MEM_WB} };
    opcode = 6'h23;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mem_ready = seq[i][22];
      #1;
      total++;
      if (state !== seq[i][21:18]) begin bad++; $display("FAIL lw_state step %0d: got %0d want %0d", i, state, seq[i][21:18]); end
      total++;
      if (ctrl !== seq[i][17:0]) begin bad++; $display("FAIL lw_ctrl step %0d: got %b want %b", i, ctrl, seq[i][17:0]); end
    end
  endtask

  task automatic test_rtype();
    logic [22:0] seq [4];
    seq = '{ {1'b1, 4'd0, C_FETCH_RDY}, {1'b1, 4'd1, C_DECODE},
             {1'b1, 4'd6, C_EXECUTE},   {1'b1, 4'd7, C_R_WB} };
    opcode = 6'h00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ready = seq[i][22];
      #1;
      total++;
      if (state !== seq[i][21:18]) begin bad++; $display("FAIL rtype_state step %0d: got %0d want %0d", i, state, seq[i][21:18]); end
      total++;
      if (ctrl !== seq[i][17:0]) begin bad++; $display("FAIL rtype_ctrl step %0d: got %b want %b", i, ctrl, seq[i][17:0]); end
    end
  endtask

  task automatic test_sw_wait();
    logic [22:0] seq [7];
    seq = '{ {1'b1, 4'd0, C_FETCH_RDY}, {1'b1, 4'd1, C_DECODE},
             {1'b1, 4'd2, C_ADDR},      {1'b0, 4'd5, C_MW_WAIT},
             {1'b0, 4'd5, C_MW_WAIT},   {1'b0, 4'd5, C_MW_WAIT},
             {1'b1, 4'd5, C_MW_RDY} };
    opcode = 6'h2B;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      mem_ready = seq[i][22];
      #1;
      total++;
      if (state !== seq[i][21:18]) begin bad++; $display("FAIL sw_state step %0d: got %0d want %0d", i, state, seq[i][21:18]); end
      total++;
      if (ctrl !== seq[i][17:0]) begin bad++; $display("FAIL sw_ctrl step %0d: got %b want %b", i, ctrl, seq[i][17:0]); end
    end
  endtask

  task automatic test_beq_j_addi();
    logic [22:0] seq [10];
    logic [5:0]  ops [10];
    seq = '{ {1'b1, 4'd0, C_FETCH_RDY}, {1'b1, 4'd1, C_DECODE}, {1'b1, 4'd8, C_BRANCH},
             {1'b1, 4'd0, C_FETCH_RDY}, {1'b1, 4'd1, C_DECODE}, {1'b1, 4'd9, C_JUMP},
             {1'b1, 4'd0, C_FETCH_RDY}, {1'b1, 4'd1, C_DECODE}, {1'b1, 4'd10, C_ADDR},
             {1'b1, 4'd11, C_ADDI_WB} };
    ops = '{ 6'h04, 6'h04, 6'h04, 6'h02, 6'h02, 6'h02, 6'h08, 6'h08, 6'h08, 6'h08 };
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mem_ready = seq[i][22];
      opcode = ops[i];
      #1;
      total++;
      if (state !== seq[i][21:18]) begin bad++; $display("FAIL bja_state step %0d: got %0d want %0d", i, state, seq[i][21:18]); end
      total++;
      if (ctrl !== seq[i][17:0]) begin bad++; $display("FAIL bja_ctrl step %0d: got %b want %b", i, ctrl, seq[i][17:0]); end
    end
  endtask

  task automatic test_illegal();
    logic [22:0] seq [3];
    seq = '{ {1'b1, 4'd0, C_FETCH_RDY}, {1'b1, 4'd1, C_DECODE_ILL},
             {1'b1, 4'd0, C_FETCH_RDY} };
    opcode = 6'h3F;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ready = seq[i][22];
      if (i == 2) opcode = 6'h23;
      #1;
      total++;
      if (state !== seq[i][21:18]) begin bad++; $display("FAIL illegal_state step %0d: got %0d want %0d", i, state, seq[i][21:18]); end
      total++;
      if (ctrl !== seq[i][17:0]) begin bad++; $display("FAIL illegal_ctrl step %0d: got %b want %b", i, ctrl, seq[i][17:0]); end
    end
  endtask

  // Entered in FETCH with opcode=lw already applied by the previous task.
  task automatic test_reset_mid_wait();
    logic [22:0] seq [3];
    seq = '{ {1'b1, 4'd1, C_DECODE}, {1'b1, 4'd2, C_ADDR}, {1'b0, 4'd3, C_MEM_READ} };
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ready = seq[i][22];
      #1;
      total++;
      if (state !== seq[i][21:18]) begin bad++; $display("FAIL rstwait_state step %0d: got %0d want %0d", i, state, seq[i][21:18]); end
      total++;
      if (ctrl !== seq[i][17:0]) begin bad++; $display("FAIL rstwait_ctrl step %0d: got %b want %b", i, ctrl, seq[i][17:0]); end
    end
    #1;
    checking = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if (state !== 4'd0) begin bad++; $display("FAIL async_rst_state: got %0d want 0", state); end
    total++;
    if (ctrl !== C_ZERO) begin bad++; $display("FAIL async_rst_ctrl: got %b want %b", ctrl, C_ZERO); end
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (ctrl !== C_ZERO) begin bad++; $display("FAIL held_rst_ctrl: got %b want %b", ctrl, C_ZERO); end
    @(negedge clk);
    rst = 1'b0;
    checking = 1'b1;
    #1;
    total++;
    if (state !== 4'd0) begin bad++; $display("FAIL post_rst_state: got %0d want 0", state); end
    total++;
    if (ctrl !== C_FETCH_RDY) begin bad++; $display("FAIL post_rst_ctrl: got %b want %b", ctrl, C_FETCH_RDY); end
    @(posedge clk);
    #1;
    total++;
    if (state !== 4'd1) begin bad++; $display("FAIL post_rst_decode: got %0d want 1", state); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_sw_wait();
    test_beq_j_addi();
    test_illegal();
    test_reset_mid_wait();
    checking = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
